// File: rtl/q_sys_pio_pkg.sv
// Shared definitions for the Qsys error-flag input PIO.
//   - Register addresses on the s1 slave (2-bit word address).
//   - Edge-capture mode encodings for the EDGE_MODE parameter.
package q_sys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAPTURE = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/q_sys_pio_sync_edge.sv
// Synchroniser, previous-sample register, arming counter and edge detector
// for the error-flag input port.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   in_port       asynchronous flag inputs
//   s             synchronised flags (output of the last sync flop)
//   e             one-cycle edge vector, forced to 0 until armed
module q_sys_pio_sync_edge
  import q_sys_pio_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] e
);

  // The chain, prev and arming all come out of reset at zero; armed rises
  // SYNC_STAGES+1 edges after reset so the one cycle where s has caught up
  // with a static input but prev has not is masked out.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_cnt;
  logic             armed_q;
  logic [WIDTH-1:0] edge_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      warm_cnt <= '0;
      armed_q  <= 1'b0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
      if (!armed_q) begin
        warm_cnt <= warm_cnt + 3'd1;
        if (warm_cnt == 3'(ARM_CYCLES - 1)) armed_q <= 1'b1;
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_raw = '0;
    case (EDGE_MODE)
      EDGE_RISE: edge_raw = s & ~prev_q;
      EDGE_FALL: edge_raw = ~s & prev_q;
      default:   edge_raw = s ^ prev_q;
    endcase
  end

  assign e = armed_q ? edge_raw : '0;

endmodule

// File: rtl/q_sys_in_port_err_capture.sv
// Avalon-MM input PIO (slave s1) for arithmetic-datapath error flags:
// synchronised DATA, per-bit edge CAPTURE with write-1-to-clear, interrupt
// MASK with a level irq, and a saturating event COUNT.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   address               register select (DATA/MASK/CAPTURE/COUNT)
//   chipselect, write_n   a write happens in any cycle with chipselect=1 and
//                         write_n=0; there is no wait state
//   writedata             write data, bits at or above WIDTH ignored
//   in_port               asynchronous error-flag inputs
//   readdata              registered mux of the register at 'address'; the
//                         value for an address presented in cycle N appears
//                         in cycle N+1. Reads have no side effects.
//   irq                   level interrupt, |(capture & mask), registered
module q_sys_in_port_err_capture
  import q_sys_pio_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     e;
  logic [WIDTH-1:0]     mask_q, mask_next;
  logic [WIDTH-1:0]     capture_q, capture_next;
  logic [WIDTH-1:0]     clr;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_next;
  logic [31:0]          rd_mux;
  logic                 wr_en;
  logic                 any_e;
  logic                 unused_wdata;

  q_sys_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .s       (s),
    .e       (e)
  );

  assign wr_en        = chipselect & ~write_n;
  assign any_e        = |e;
  assign unused_wdata = ^writedata;

  always_comb begin
    clr       = '0;
    mask_next = mask_q;
    cnt_next  = cnt_q;
    if (wr_en && address == ADDR_CAPTURE) clr = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_MASK) mask_next = writedata[WIDTH-1:0];
    // Clear is applied before OR-ing in new edges, so a same-cycle set wins.
    capture_next = (capture_q & ~clr) | e;
    if (wr_en && address == ADDR_COUNT) begin
      // A clear racing an event keeps that event.
      cnt_next = any_e ? CNT_WIDTH'(1) : '0;
    end else if (any_e && cnt_q != '1) begin
      cnt_next = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0]     = s;
      ADDR_MASK:    rd_mux[WIDTH-1:0]     = mask_q;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0]     = capture_q;
      default:      rd_mux[CNT_WIDTH-1:0] = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      capture_q <= '0;
      cnt_q     <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      mask_q    <= mask_next;
      capture_q <= capture_next;
      cnt_q     <= cnt_next;
      readdata  <= rd_mux;
      // Built from next-state values so clears and mask writes drop irq
      // on the same edge that updates the registers.
      irq       <= |(capture_next & mask_next);
    end
  end

endmodule

// File: tb/tb_q_sys_in_port_err_capture.sv
module tb_q_sys_in_port_err_capture;
  import q_sys_pio_pkg::*;

  localparam int W = 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs_r, cs_a, write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_r, in_a;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // dut_r: rising-edge mode with a 4-bit counter; dut_a: any-edge mode.
  q_sys_in_port_err_capture #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .CNT_WIDTH(4)
  ) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_r),
    .write_n(write_n), .writedata(writedata), .in_port(in_r),
    .readdata(rd_r), .irq(irq_r)
  );

  q_sys_in_port_err_capture #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(EDGE_ANY), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic        sel;
    logic        is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      c = exp_q.pop_front();
      if (c.is_irq) got = {31'b0, (c.sel ? irq_a : irq_r)};
      else          got = c.sel ? rd_a : rd_r;
      n_vec++;
      if (c.due != cyc || got !== c.exp) begin
        n_miss++;
        $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                 c.name, got, c.exp, cyc, c.due);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_r      = !sel;
    cs_a      = sel;
    step(1);
    write_n   = 1'b1;
    cs_r      = 1'b0;
    cs_a      = 1'b0;
  endtask

  // readdata for this address is expected after the next edge.
  task automatic rd(input logic sel, input logic [1:0] a, input logic [31:0] x,
                    input string nm);
    chk_t c;
    address  = a;
    c.due    = cyc + 1;
    c.sel    = sel;
    c.is_irq = 1'b0;
    c.exp    = x;
    c.name   = nm;
    exp_q.push_back(c);
    step(1);
  endtask

  // irq is expected to hold this value in the current cycle.
  task automatic chk_irq(input logic sel, input logic x, input string nm);
    chk_t c;
    c.due    = cyc;
    c.sel    = sel;
    c.is_irq = 1'b1;
    c.exp    = {31'b0, x};
    c.name   = nm;
    exp_q.push_back(c);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset     = 1'b1;
    address   = ADDR_DATA;
    cs_r      = 1'b0;
    cs_a      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
    in_r      = 20'h00001;
    in_a      = 20'h00001;
    step(1);
    chk_irq(0, 1'b0, "irq_in_reset");
    rd(0, ADDR_DATA, 32'h0, "readdata_in_reset");
    step(1);
    reset = 1'b0;

    // Arming: level present through reset is not an edge.
    step(10);
    rd(0, ADDR_CAPTURE, 32'h0, "arm_capture");
    rd(0, ADDR_COUNT, 32'h0, "arm_count");
    rd(0, ADDR_DATA, 32'h1, "arm_data");
    rd(0, ADDR_MASK, 32'h0, "reset_mask");
    chk_irq(0, 1'b0, "arm_irq");
    rd(1, ADDR_CAPTURE, 32'h0, "arm_capture_any");

    // Rising edge on bit4 with bit4 unmasked.
    in_r = '0;
    step(5);
    wr(0, ADDR_MASK, 32'h10);
    in_r = 20'h00010;
    step(2);
    chk_irq(0, 1'b0, "irq_before_edge");
    rd(0, ADDR_CAPTURE, 32'h0, "capture_before_edge");
    rd(0, ADDR_CAPTURE, 32'h10, "capture_edge_latency");
    chk_irq(0, 1'b1, "irq_after_edge");
    rd(0, ADDR_COUNT, 32'h1, "count_first_edge");

    // Clear collides with a new bit4 edge: set wins.
    in_r = '0;
    step(4);
    in_r = 20'h00010;
    step(2);
    wr(0, ADDR_CAPTURE, 32'h10);
    chk_irq(0, 1'b1, "irq_collision");
    rd(0, ADDR_CAPTURE, 32'h10, "collision_set_wins");
    wr(0, ADDR_CAPTURE, 32'h10);
    chk_irq(0, 1'b0, "irq_after_clear");
    rd(0, ADDR_CAPTURE, 32'h0, "capture_cleared");
    rd(0, ADDR_COUNT, 32'h2, "count_second_edge");

    // Masked event on bit7, then unmask with junk above WIDTH.
    wr(0, ADDR_MASK, 32'h0);
    in_r = 20'h00090;
    step(4);
    chk_irq(0, 1'b0, "irq_masked");
    rd(0, ADDR_CAPTURE, 32'h80, "capture_masked");
    rd(0, ADDR_COUNT, 32'h3, "count_masked");
    wr(0, ADDR_MASK, 32'hFFF0_0080);
    chk_irq(0, 1'b1, "irq_unmask");
    rd(0, ADDR_MASK, 32'h80, "mask_upper_bits_dropped");
    wr(0, ADDR_DATA, 32'hFFFF_FFFF);
    rd(0, ADDR_DATA, 32'h90, "data_write_ignored");

    // Saturation of the 4-bit counter.
    wr(0, ADDR_COUNT, 32'h0);
    rd(0, ADDR_COUNT, 32'h0, "count_cleared");
    for (int i = 0; i < 14; i++) begin
      in_r[0] = 1'b1; step(2);
      in_r[0] = 1'b0; step(2);
    end
    step(2);
    rd(0, ADDR_COUNT, 32'hE, "count_14_edges");
    for (int i = 0; i < 6; i++) begin
      in_r[0] = 1'b1; step(2);
      in_r[0] = 1'b0; step(2);
    end
    step(2);
    rd(0, ADDR_COUNT, 32'hF, "count_saturated");
    in_r[0] = 1'b1;
    step(2);
    wr(0, ADDR_COUNT, 32'h0);
    rd(0, ADDR_COUNT, 32'h1, "count_clear_with_event");
    in_r[0] = 1'b0;
    step(4);
    wr(0, ADDR_COUNT, 32'h1234);
    rd(0, ADDR_COUNT, 32'h0, "count_clear_alone");

    // Any-edge mode: bit0 1->0->1 counts two events.
    wr(1, ADDR_MASK, 32'h1);
    in_a = '0;
    step(3);
    rd(1, ADDR_COUNT, 32'h1, "any_fall_counted");
    in_a = 20'h00001;
    step(4);
    rd(1, ADDR_COUNT, 32'h2, "any_two_edges");
    rd(1, ADDR_CAPTURE, 32'h1, "any_capture");
    chk_irq(1, 1'b1, "any_irq");

    // Reset mid-operation with a write in flight.
    cs_a      = 1'b1;
    write_n   = 1'b0;
    writedata = 32'h000F_FFFF;
    reset     = 1'b1;
    rd(1, ADDR_MASK, 32'h0, "readdata_mid_reset");
    write_n   = 1'b1;
    cs_a      = 1'b0;
    chk_irq(1, 1'b0, "irq_mid_reset");
    reset     = 1'b0;
    step(6);
    rd(1, ADDR_MASK, 32'h0, "mask_after_reset");
    rd(1, ADDR_CAPTURE, 32'h0, "no_spurious_capture");
    rd(1, ADDR_COUNT, 32'h0, "count_after_reset");
    chk_irq(1, 1'b0, "irq_after_reset");
    rd(1, ADDR_DATA, 32'h1, "data_after_reset");
    rd(0, ADDR_CAPTURE, 32'h0, "capture_r_after_reset");
    rd(0, ADDR_COUNT, 32'h0, "count_r_after_reset");
    chk_irq(0, 1'b0, "irq_r_after_reset");

    // ---------------- report ----------------
    step(3);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %0d expectations never evaluated", exp_q.size());
    end
    if (n_vec < 12) begin
      n_miss++;
      $display("FAIL only %0d vectors evaluated", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
